pointwise_stream_harness: RTL and testbench
===========================================

Name: pointwise_stream_harness

Overview:
- Drive-side and capture-side counterpart of the registered pointwise wrapper around DesignTop.
- Generates a stream of 16-bit stimulus vectors into the wrapper's `in`.
- Aligns returning `out` words to the wrapper's fixed pipeline latency and compacts them into a 16-bit MISR signature.
- Used in silicon/FPGA bring-up to check a pointwise datapath without an external pattern source.

Parameters:
- COUNT_W, 16, width of vector count and output counters.
- LATENCY, 2, register stages between wrapper `in` and wrapper `out` (in_r + out_r).
- MISR_POLY, 16'h1021, feedback polynomial of the signature register.
- LFSR_POLY, 16'hB400, Galois feedback taps for LFSR stimulus (maximal length).

Ports:
- clk  input  1  sole clock; wrapper on same clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- num_vectors  input  COUNT_W  vectors to issue; captured on accepted start.
- seed  input  16  first stimulus value; captured on accepted start.
- pw_in  output  16  registered stimulus, connects to wrapper `in`.
- pw_out  input  16  wrapper `out`.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE until next accepted start.
- signature  output  16  MISR contents.
- out_count  output  COUNT_W  number of words captured this run.

Behaviour:
- Reset (rst=0, async): state IDLE; pw_in=0, busy=0, done=0, signature=0, out_count=0, issue counter=0, valid pipe cleared.
  - Reset mid-run aborts with no partial done.
- States: IDLE, RUN, DRAIN, DONE.
- Accepted start (IDLE or DONE, start=1):
  - Clear signature, out_count, and valid pipe.
  - Stimulus register <= first vector (seed; see Optional Feature for the zero-seed rule).
  - num_vectors=0: go straight to DONE next edge. done=1, signature=0, out_count=0, pw_in stays 0.
  - Otherwise, on that same edge: pw_in <= first vector, issue counter=1, valid pipe input=1, state RUN.
  - If num_vectors==1, state goes to DRAIN instead of RUN.
- start while busy is ignored.
- RUN, each edge:
  - pw_in <= next vector; issue counter++; valid pipe input=1.
  - When the issue counter reaches num_vectors on this edge, go to DRAIN.
- DRAIN: pw_in <= 0; valid pipe input=0.
- Valid pipe: LATENCY+1 stages, aligned so the word driven on pw_in at edge t is sampled from pw_out at edge t+LATENCY+1.
- Capture (any state, valid pipe tail=1):
  - signature <= ({sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0)) ^ pw_out.
  - out_count++.
- DRAIN -> DONE on the edge where the last valid bit is captured; done and signature are coherent on that same edge.
- Timing: start accepted at edge k with N>0 -> done first high after edge k+N+LATENCY.
- Counter stimulus: next = current + 1, wrapping 16'hFFFF -> 16'h0000.
- pw_out is ignored when the valid tail bit is 0 (X-safe).
- Counters wrap modulo 2^COUNT_W. A run of 2^COUNT_W-1 vectors is the maximum.

Optional Feature:
- Macro: PW_HARNESS_LFSR_STIM_EN.
- Defined: stimulus is a 16-bit Galois LFSR, next = (v>>1) ^ (v[0] ? LFSR_POLY : 0). A seed of 0 is replaced by 16'h0001.
- Undefined: stimulus is the incrementing counter above; seed 0 is used as-is.

Test Plan:
- Counter mode, identity DesignTop stub, seed=16'h0010, num_vectors=4:
  - pw_in 0010,0011,0012,0013 on consecutive edges.
  - done after edge start+6; out_count=4; signature=16'h00F3.
- num_vectors=0, seed=16'h1234: done one edge after start; busy never high; signature=0; pw_in stays 0.
- Counter mode, seed=16'hFFFE, num_vectors=3: pw_in FFFE,FFFF,0000 (wrap); out_count=3.
- start pulsed again mid-RUN with different seed: ignored; run completes with the original stimulus and signature.
- rst pulled low during DRAIN of a 4-vector run: all outputs 0 immediately (async).
  - A new start, seed=16'h0010, num_vectors=4, still yields signature 16'h00F3.
- PW_HARNESS_LFSR_STIM_EN defined, seed=0, num_vectors=3: pw_in 0001,B400,5A00; out_count=3.

Source files
------------

// File: rtl/pointwise_stream_harness.sv
// Stimulus generator and latency-aligned MISR capture for a pointwise wrapper.
// Define PW_HARNESS_LFSR_STIM_EN for Galois LFSR stimulus instead of a counter.
module pointwise_stream_harness #(
  parameter int          COUNT_W   = 16,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] MISR_POLY = 16'h1021,
  parameter logic [15:0] LFSR_POLY = 16'hB400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vectors,
  input  logic [15:0]        seed,
  output logic [15:0]        pw_in,
  input  logic [15:0]        pw_out,
  output logic               busy,
  output logic               done,
  output logic [15:0]        signature,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LATENCY:0] HEAD_MASK =
    {1'b0, {LATENCY{1'b1}}};

  state_t             state;
  state_t             state_nx;
  logic [15:0]        stim;
  logic [15:0]        stim_nx;
  logic [15:0]        first_vec;
  logic [15:0]        misr_nx;
  logic [COUNT_W-1:0] issued;
  logic [COUNT_W-1:0] issued_inc;
  logic [COUNT_W-1:0] target;
  logic [LATENCY:0]   vpipe;
  logic               accept;
  logic               nv_zero;
  logic               nv_one;
  logic               tail;
  logic               last;

  function automatic logic [15:0] next_vec(
    input logic [15:0] v
  );
`ifdef PW_HARNESS_LFSR_STIM_EN
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
`else
    return v + 16'h0001;
`endif
  endfunction

`ifdef PW_HARNESS_LFSR_STIM_EN
  // An all-zero LFSR would lock up, so zero seeds start at 1.
  assign first_vec = (seed == 16'h0000) ? 16'h0001 : seed;
`else
  assign first_vec = seed;
`endif

  assign accept     = start && (state == IDLE || state == DONE);
  assign nv_zero    = (num_vectors == '0);
  assign nv_one     = (num_vectors == COUNT_W'(1));
  assign issued_inc = issued + 1'b1;
  assign stim_nx    = next_vec(stim);
  assign tail       = vpipe[LATENCY];
  assign last       = tail && ((vpipe & HEAD_MASK) == '0);

  assign misr_nx = {signature[14:0], 1'b0}
                 ^ (signature[15] ? MISR_POLY : 16'h0000)
                 ^ pw_out;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (nv_zero) begin
            state_nx = DONE;
          end else if (nv_one) begin
            state_nx = DRAIN;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (issued_inc == target) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pw_in     <= 16'h0000;
      stim      <= 16'h0000;
      issued    <= '0;
      target    <= '0;
      vpipe     <= '0;
      signature <= 16'h0000;
      out_count <= '0;
    end else if (accept) begin
      target    <= num_vectors;
      stim      <= first_vec;
      signature <= 16'h0000;
      out_count <= '0;
      if (nv_zero) begin
        pw_in  <= 16'h0000;
        issued <= '0;
        vpipe  <= '0;
      end else begin
        pw_in  <= first_vec;
        issued <= COUNT_W'(1);
        vpipe  <= {{LATENCY{1'b0}}, 1'b1};
      end
    end else begin
      vpipe <= {vpipe[LATENCY-1:0], state == RUN};
      if (state == RUN) begin
        pw_in  <= stim_nx;
        stim   <= stim_nx;
        issued <= issued_inc;
      end else begin
        pw_in <= 16'h0000;
      end
      // pw_out only matters when the tail flags a live word.
      if (tail) begin
        signature <= misr_nx;
        out_count <= out_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pointwise_stream_harness.sv
// Bench for pointwise_stream_harness with a two-stage wrapper stub.
// Timeline model relative to the accepting edge, checked every cycle.
module tb_pointwise_stream_harness;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vectors = 16'h0000;
  logic [15:0] seed = 16'h0000;
  logic [15:0] pw_in;
  logic [15:0] pw_out;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] out_count;

  logic [15:0] in_r;
  logic [15:0] out_r;
  logic [15:0] xmask = 16'h0000;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int k = 0;
  int run_n = 0;
  int first_done = -1;
  bit model_on = 1'b0;
  logic [15:0] run_mask = 16'h0000;
  logic [15:0] vec [0:63];
  logic [15:0] obs_pw [0:7];

  pointwise_stream_harness dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .seed        (seed),
    .pw_in       (pw_in),
    .pw_out      (pw_out),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_r  <= 16'h0000;
      out_r <= 16'h0000;
    end else begin
      in_r  <= pw_in;
      out_r <= in_r ^ xmask;
    end
  end
  assign pw_out = out_r;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [15:0] model_next(input logic [15:0] v);
`ifdef PW_HARNESS_LFSR_STIM_EN
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
`else
    return v + 16'h0001;
`endif
  endfunction

  function automatic logic [15:0] model_first(input logic [15:0] s);
`ifdef PW_HARNESS_LFSR_STIM_EN
    return (s == 16'h0000) ? 16'h0001 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [15:0] sig_after(input int m);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < m; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
        ^ (vec[i] ^ run_mask);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_on && rst) begin
      int j;
      int c;
      logic [15:0] pw_e;
      logic busy_e;
      logic done_e;
      j = edge_cnt - k;
      pw_e = (j < run_n) ? vec[j] : 16'h0000;
      busy_e = (run_n > 0) && (j < run_n + LAT);
      done_e = (run_n == 0) || (j >= run_n + LAT);
      c = j - LAT;
      if (c < 0) c = 0;
      if (c > run_n) c = run_n;
      if (run_n == 0) c = 0;
      if (j < 8) obs_pw[j] = pw_in;
      if (done && first_done < 0) first_done = j;
      tests++;
      if (pw_in !== pw_e || busy !== busy_e || done !== done_e ||
          out_count !== 16'(c) || signature !== sig_after(c)) begin
        fails++;
        $display("FAIL cycle j=%0d: pw_in=%h busy=%b done=%b cnt=%0d sig=%h expected pw_in=%h busy=%b done=%b cnt=%0d sig=%h",
                 j, pw_in, busy, done, out_count, signature,
                 pw_e, busy_e, done_e, c, sig_after(c));
      end
    end
  end

  task automatic start_run(input logic [15:0] s, input int n);
    @(negedge clk);
    model_on = 1'b0;
    start = 1'b1;
    seed = s;
    num_vectors = 16'(n);
    vec[0] = model_first(s);
    for (int i = 1; i < 64; i++) vec[i] = model_next(vec[i-1]);
    run_n = n;
    run_mask = xmask;
    first_done = -1;
    for (int i = 0; i < 8; i++) obs_pw[i] = 16'hxxxx;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = edge_cnt;
    model_on = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = done;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: done=%b expected 1", done);
    end
  endtask

  initial begin
    #12;
    check("reset pw_in", pw_in, 16'h0000);
    check("reset busy", {15'h0, busy}, 16'h0000);
    check("reset done", {15'h0, done}, 16'h0000);
    check("reset sig", signature, 16'h0000);
    check("reset cnt", out_count, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    start_run(16'h0010, 4);
    wait_done(40);
    check("t1 pw0", obs_pw[0], 16'h0010);
    check("t1 pw1", obs_pw[1], 16'h0011);
    check("t1 pw2", obs_pw[2], 16'h0012);
    check("t1 pw3", obs_pw[3], 16'h0013);
    check("t1 done_at", 16'(first_done), 16'd6);
    check("t1 cnt", out_count, 16'd4);
    check("t1 sig", signature, 16'h00F3);

    start_run(16'h1234, 0);
    wait_done(10);
    check("t2 done_at", 16'(first_done), 16'd0);
    check("t2 sig", signature, 16'h0000);
    check("t2 pw_in", pw_in, 16'h0000);
    check("t2 cnt", out_count, 16'h0000);

`ifndef PW_HARNESS_LFSR_STIM_EN
    start_run(16'hFFFE, 3);
    wait_done(40);
    check("t3 pw0", obs_pw[0], 16'hFFFE);
    check("t3 pw1", obs_pw[1], 16'hFFFF);
    check("t3 pw2", obs_pw[2], 16'h0000);
    check("t3 cnt", out_count, 16'd3);
`endif

    start_run(16'h0010, 4);
    @(negedge clk);
    start = 1'b1;
    seed = 16'hABCD;
    num_vectors = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40);
    check("t4 cnt", out_count, 16'd4);
    check("t4 sig", signature, 16'h00F3);

    start_run(16'h0010, 4);
    for (int i = 0; i < 20 && (edge_cnt - k) < 4; i++) @(negedge clk);
    model_on = 1'b0;
    check("t5 busy_before", {15'h0, busy}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    check("t5 rst pw_in", pw_in, 16'h0000);
    check("t5 rst busy", {15'h0, busy}, 16'h0000);
    check("t5 rst done", {15'h0, done}, 16'h0000);
    check("t5 rst sig", signature, 16'h0000);
    check("t5 rst cnt", out_count, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    start_run(16'h0010, 4);
    wait_done(40);
    check("t5 sig", signature, 16'h00F3);
    check("t5 cnt", out_count, 16'd4);

`ifdef PW_HARNESS_LFSR_STIM_EN
    start_run(16'h0000, 3);
    wait_done(40);
    check("t6 pw0", obs_pw[0], 16'h0001);
    check("t6 pw1", obs_pw[1], 16'hB400);
    check("t6 pw2", obs_pw[2], 16'h5A00);
    check("t6 cnt", out_count, 16'd3);
`endif

    for (int r = 0; r < 10; r++) begin
      int n;
      logic [15:0] s;
      n = $urandom_range(0, 12);
      s = 16'($urandom);
      xmask = 16'($urandom);
      start_run(s, n);
      wait_done(60);
      check("rand cnt", out_count, 16'(n));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
